// File: rtl/txp_pkg.sv
// Shared types and defaults for the transaction processor: FSM state encodings,
// default account geometry and the write-back phase code seen by the memory controller.
package txp_pkg;

    localparam int TXP_BAL_W     = 16;
    localparam int TXP_NUM_ACCTS = 3;

    localparam logic [2:0] PROC_COMMIT = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_REQUEST   = 3'b001,
        ST_WAIT_LOAD = 3'b010,
        ST_COMPUTE   = 3'b011,
        ST_COMMIT    = PROC_COMMIT
    } txp_state_e;

endpackage

// File: rtl/balance_update.sv
// Combinational transfer check and updated-word computation for one packed account word.
// With TX_PROC_OVERFLOW_CHECK_EN defined, a destination sum above 2^BAL_W-1 is rejected instead of wrapping.
module balance_update
    import txp_pkg::*;
#(
    parameter int BAL_W     = TXP_BAL_W,
    parameter int NUM_ACCTS = TXP_NUM_ACCTS
) (
    input  logic [NUM_ACCTS*BAL_W-1:0] word_i,
    input  logic [1:0]                 from_i,
    input  logic [1:0]                 to_i,
    input  logic [BAL_W-1:0]           amount_i,
    output logic                       accept_o,
    output logic [NUM_ACCTS*BAL_W-1:0] word_o
);

    logic [BAL_W-1:0] from_bal;
    logic [BAL_W-1:0] to_bal;
    logic [BAL_W-1:0] from_new;
    logic [BAL_W-1:0] to_new;
    logic             idx_ok;
    logic             distinct;
    logic             funds_ok;
    logic             ovf;

    // Out-of-range indices select nothing; their balance reads as zero and the transfer is rejected anyway.
    always_comb begin
        from_bal = '0;
        to_bal   = '0;
        for (int k = 0; k < NUM_ACCTS; k++) begin
            if (int'(from_i) == k) from_bal = word_i[k*BAL_W +: BAL_W];
            if (int'(to_i) == k)   to_bal   = word_i[k*BAL_W +: BAL_W];
        end
    end

    assign from_new = from_bal - amount_i;

`ifdef TX_PROC_OVERFLOW_CHECK_EN
    logic [BAL_W:0] to_sum_wide;
    assign to_sum_wide = {1'b0, to_bal} + {1'b0, amount_i};
    assign to_new      = to_sum_wide[BAL_W-1:0];
    assign ovf         = to_sum_wide[BAL_W];
`else
    assign to_new = to_bal + amount_i;
    assign ovf    = 1'b0;
`endif

    assign idx_ok   = (int'(from_i) < NUM_ACCTS) && (int'(to_i) < NUM_ACCTS);
    assign distinct = (from_i != to_i);
    assign funds_ok = (from_bal >= amount_i);
    assign accept_o = idx_ok && distinct && funds_ok && !ovf;

    always_comb begin
        word_o = word_i;
        if (accept_o) begin
            for (int k = 0; k < NUM_ACCTS; k++) begin
                if (int'(from_i) == k) word_o[k*BAL_W +: BAL_W] = from_new;
                if (int'(to_i) == k)   word_o[k*BAL_W +: BAL_W] = to_new;
            end
        end
    end

endmodule

// File: rtl/transaction_processor.sv
// Transfers funds between accounts of one packed memory word through a read-modify-write cycle.
// Optional build macro TX_PROC_OVERFLOW_CHECK_EN (handled in balance_update) rejects destination overflow.
module transaction_processor
    import txp_pkg::*;
#(
    parameter int BAL_W     = TXP_BAL_W,
    parameter int NUM_ACCTS = TXP_NUM_ACCTS
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [NUM_ACCTS*BAL_W-1:0] mem_q,
    input  logic                       load_registers,
    input  logic                       done,
    output logic                       load_memory,
    output logic [2:0]                 process,
    output logic [NUM_ACCTS*BAL_W-1:0] datapath_out,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    input  logic [1:0]                 tx_from,
    input  logic [1:0]                 tx_to,
    input  logic [BAL_W-1:0]           tx_amount,
    output logic                       tx_done,
    output logic                       tx_ok
);

    localparam int WORD_W = NUM_ACCTS * BAL_W;

    txp_state_e        state_q, state_d;
    logic [WORD_W-1:0] balance_q;
    logic [WORD_W-1:0] dout_q;
    logic [WORD_W-1:0] new_word;
    logic [1:0]        from_q;
    logic [1:0]        to_q;
    logic [BAL_W-1:0]  amount_q;
    logic              lr_q;
    logic              accept_q;
    logic              tx_done_q;
    logic              tx_ok_q;
    logic              accept;
    logic              handshake;

    balance_update #(
        .BAL_W     (BAL_W),
        .NUM_ACCTS (NUM_ACCTS)
    ) u_balance_update (
        .word_i   (balance_q),
        .from_i   (from_q),
        .to_i     (to_q),
        .amount_i (amount_q),
        .accept_o (accept),
        .word_o   (new_word)
    );

    always_comb begin
        state_d     = state_q;
        handshake   = 1'b0;
        tx_ready    = 1'b0;
        load_memory = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tx_ready  = done;
                handshake = tx_valid && done;
                if (handshake) state_d = ST_REQUEST;
            end
            ST_REQUEST: begin
                load_memory = 1'b1;
                if (!done) state_d = ST_WAIT_LOAD;
            end
            // Leave on the falling edge of the load strobe, once the last word has been captured.
            ST_WAIT_LOAD: if (lr_q && !load_registers) state_d = ST_COMPUTE;
            ST_COMPUTE:   state_d = ST_COMMIT;
            ST_COMMIT:    if (done) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            balance_q <= '0;
            dout_q    <= '0;
            from_q    <= '0;
            to_q      <= '0;
            amount_q  <= '0;
            lr_q      <= 1'b0;
            accept_q  <= 1'b0;
            tx_done_q <= 1'b0;
            tx_ok_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lr_q      <= (state_q == ST_WAIT_LOAD) && load_registers;
            tx_done_q <= (state_q == ST_COMMIT) && done;
            tx_ok_q   <= (state_q == ST_COMMIT) && done && accept_q;
            if (handshake) begin
                from_q   <= tx_from;
                to_q     <= tx_to;
                amount_q <= tx_amount;
            end
            if ((state_q == ST_WAIT_LOAD) && load_registers) balance_q <= mem_q;
            if (state_q == ST_COMPUTE) begin
                dout_q   <= new_word;
                accept_q <= accept;
            end
        end
    end

    assign process      = state_q;
    assign datapath_out = dout_q;
    assign tx_done      = tx_done_q;
    assign tx_ok        = tx_ok_q;

endmodule

// File: tb/tb_transaction_processor.sv
// Self-checking bench for transaction_processor: directed and randomized transfers
// against a per-account balance model, with the bench acting as the memory controller.
module tb_transaction_processor;

    localparam int BAL_W     = 16;
    localparam int NUM_ACCTS = 3;
    localparam int WORD_W    = BAL_W * NUM_ACCTS;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic [WORD_W-1:0] mem_q = '0;
    logic              load_registers = 1'b0;
    logic              done = 1'b1;
    logic              load_memory;
    logic [2:0]        process;
    logic [WORD_W-1:0] datapath_out;
    logic              tx_valid = 1'b0;
    logic              tx_ready;
    logic [1:0]        tx_from = '0;
    logic [1:0]        tx_to = '0;
    logic [BAL_W-1:0]  tx_amount = '0;
    logic              tx_done;
    logic              tx_ok;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    transaction_processor #(.BAL_W(BAL_W), .NUM_ACCTS(NUM_ACCTS)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .mem_q          (mem_q),
        .load_registers (load_registers),
        .done           (done),
        .load_memory    (load_memory),
        .process        (process),
        .datapath_out   (datapath_out),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_from        (tx_from),
        .tx_to          (tx_to),
        .tx_amount      (tx_amount),
        .tx_done        (tx_done),
        .tx_ok          (tx_ok)
    );

    // Account-level model: balances as plain integers, transfer rules applied directly.
    function automatic void model(input logic [WORD_W-1:0] w, input int f, input int t, input int a,
                                  output logic [WORD_W-1:0] nw, output bit ok);
        int bal[NUM_ACCTS];
        for (int k = 0; k < NUM_ACCTS; k++) bal[k] = int'(w[k*BAL_W +: BAL_W]);
        ok = 1'b1;
        if (f == t || f >= NUM_ACCTS || t >= NUM_ACCTS) ok = 1'b0;
        else if (bal[f] < a) ok = 1'b0;
`ifdef TX_PROC_OVERFLOW_CHECK_EN
        else if (bal[t] + a > 65535) ok = 1'b0;
`endif
        nw = w;
        if (ok) begin
            bal[f] = bal[f] - a;
            bal[t] = (bal[t] + a) % 65536;
            for (int k = 0; k < NUM_ACCTS; k++) nw[k*BAL_W +: BAL_W] = bal[k][BAL_W-1:0];
        end
    endfunction

    // One full transaction; called at a negedge with the DUT idle.
    task automatic run_tx(input string name, input logic [1:0] f, input logic [1:0] t,
                          input logic [BAL_W-1:0] a, input logic [WORD_W-1:0] w,
                          input int rd_lat, input int wr_lat, input bit hold);
        logic [WORD_W-1:0] exp_w;
        logic [WORD_W-1:0] held;
        bit                exp_ok;
        model(w, int'(f), int'(t), int'(a), exp_w, exp_ok);
        done = 1'b1;
        tx_from = f; tx_to = t; tx_amount = a; tx_valid = 1'b1;
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_idle: got %b want 1", name, tx_ready);
        end
        @(negedge clock);
        if (!hold) tx_valid = 1'b0;
        tx_from = 2'($urandom); tx_to = 2'($urandom); tx_amount = 16'($urandom);
        checks++;
        if (process !== 3'b001 || load_memory !== 1'b1) begin
            errors++; $display("FAIL %s request: process %b load_memory %b want 001/1", name, process, load_memory);
        end
        for (int i = 0; i < rd_lat; i++) begin
            @(negedge clock);
            checks++;
            if (load_memory !== 1'b1 || (hold && tx_ready !== 1'b0)) begin
                errors++; $display("FAIL %s request_hold: load_memory %b tx_ready %b", name, load_memory, tx_ready);
            end
        end
        done = 1'b0;
        @(negedge clock);
        checks++;
        if (process !== 3'b010 || load_memory !== 1'b0) begin
            errors++; $display("FAIL %s wait_load: process %b load_memory %b want 010/0", name, process, load_memory);
        end
        mem_q = {16'($urandom), 32'($urandom)};
        load_registers = 1'b1;
        @(negedge clock);
        mem_q = w;
        @(negedge clock);
        load_registers = 1'b0;
        mem_q = {16'($urandom), 32'($urandom)};
        @(negedge clock);
        checks++;
        if (process !== 3'b011 || (hold && tx_ready !== 1'b0)) begin
            errors++; $display("FAIL %s compute: process %b tx_ready %b want 011/0", name, process, tx_ready);
        end
        @(negedge clock);
        checks++;
        if (process !== 3'b100 || datapath_out !== exp_w) begin
            errors++; $display("FAIL %s commit: process %b data %h want 100/%h", name, process, datapath_out, exp_w);
        end
        held = exp_w;
        for (int i = 0; i < wr_lat; i++) begin
            @(negedge clock);
            checks++;
            if (process !== 3'b100 || datapath_out !== held || tx_done !== 1'b0 || (hold && tx_ready !== 1'b0)) begin
                errors++; $display("FAIL %s commit_hold: process %b data %h tx_done %b tx_ready %b",
                                   name, process, datapath_out, tx_done, tx_ready);
            end
        end
        done = 1'b1;
        @(negedge clock);
        checks++;
        if (tx_done !== 1'b1 || tx_ok !== exp_ok || process !== 3'b000 || tx_ready !== 1'b1) begin
            errors++; $display("FAIL %s completion: tx_done %b tx_ok %b process %b tx_ready %b want 1/%b/000/1",
                               name, tx_done, tx_ok, process, tx_ready, exp_ok);
        end
        tx_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (tx_done !== 1'b0) begin
            errors++; $display("FAIL %s pulse_width: tx_done %b want 0", name, tx_done);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; done = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (process !== 3'b000 || load_memory !== 1'b0 || tx_done !== 1'b0 || tx_ok !== 1'b0 || datapath_out !== '0) begin
            errors++; $display("FAIL reset_state: process %b load_memory %b tx_done %b tx_ok %b data %h",
                               process, load_memory, tx_done, tx_ok, datapath_out);
        end
        resetn = 1'b1;
        @(negedge clock);
        checks++;
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_hi: got %b want 1", tx_ready); end
        done = 1'b0;
        #1;
        checks++;
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_lo: got %b want 0", tx_ready); end
        @(negedge clock);
        done = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_directed();
        run_tx("basic",     2'd0, 2'd1, 16'd4, 48'h0003_0005_000A, 1, 2, 1'b0);
        run_tx("no_funds",  2'd2, 2'd0, 16'd4, 48'h0003_0005_000A, 0, 1, 1'b0);
        run_tx("self",      2'd1, 2'd1, 16'd1, 48'h0003_0005_000A, 2, 0, 1'b0);
        run_tx("idx3",      2'd1, 2'd3, 16'd1, 48'h0003_0005_000A, 0, 3, 1'b0);
        run_tx("zero_amt",  2'd2, 2'd1, 16'd0, 48'h0003_0005_000A, 1, 1, 1'b0);
        run_tx("overflow",  2'd0, 2'd1, 16'd1, 48'h0003_FFFF_000A, 1, 1, 1'b0);
        run_tx("exact_bal", 2'd1, 2'd2, 16'd5, 48'h0003_0005_000A, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [WORD_W-1:0] w;
        logic [1:0]        f;
        logic [1:0]        t;
        logic [BAL_W-1:0]  a;
        for (int n = 0; n < 30; n++) begin
            w = {16'($urandom), 32'($urandom)};
            if (n % 3 == 0) w = w & 48'h0FFF_0FFF_0FFF;
            f = 2'($urandom); t = 2'($urandom);
            a = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4095));
            run_tx("random", f, t, a, w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        run_tx("busy_a", 2'd0, 2'd2, 16'd7, 48'h0010_0020_0030, 2, 2, 1'b1);
        run_tx("busy_b", 2'd2, 2'd0, 16'd9, 48'h0010_0020_0030, 1, 3, 1'b1);
    endtask

    task automatic test_reset_mid();
        int pulses;
        done = 1'b1;
        tx_from = 2'd0; tx_to = 2'd1; tx_amount = 16'd1; tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        done = 1'b0;
        @(negedge clock);
        mem_q = 48'h0001_0002_0003;
        load_registers = 1'b1;
        @(negedge clock);
        checks++;
        if (process !== 3'b010) begin errors++; $display("FAIL abort_setup: process %b want 010", process); end
        resetn = 1'b0;
        @(negedge clock);
        checks++;
        if (process !== 3'b000 || datapath_out !== '0 || load_memory !== 1'b0 || tx_done !== 1'b0 || tx_ok !== 1'b0) begin
            errors++; $display("FAIL abort_state: process %b data %h load_memory %b tx_done %b tx_ok %b",
                               process, datapath_out, load_memory, tx_done, tx_ok);
        end
        resetn = 1'b1;
        load_registers = 1'b0;
        done = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (tx_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || process !== 3'b000 || tx_ready !== 1'b1) begin
            errors++; $display("FAIL abort_quiet: tx_done pulses %0d process %b tx_ready %b want 0/000/1",
                               pulses, process, tx_ready);
        end
        run_tx("after_abort", 2'd0, 2'd2, 16'd3, 48'h0001_0002_0003, 0, 1, 1'b0);
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/transaction_processor.md
TRANSACTION_PROCESSOR -- requirements
Module: transaction_processor

Interface
REQ-001 Parameter BAL_W, default 16: width of one account balance.
REQ-002 Parameter NUM_ACCTS, default 3: accounts packed in one memory word, NUM_ACCTS*BAL_W = 48.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 resetn  input  1  synchronous, active-low reset; clock clock.
REQ-005 mem_q  input  48  memory read word; account k occupies bits [k*BAL_W +: BAL_W].
REQ-006 load_registers  input  1  memory-controller strobe: mem_q valid while high.
REQ-007 done  input  1  memory controller idle and ready for a request.
REQ-008 load_memory  output  1  request one read-modify-write cycle from the memory controller.
REQ-009 process  output  3  datapath phase code; 3'b100 means result ready for write-back.
REQ-010 datapath_out  output  48  updated word for write-back.
REQ-011 tx_valid  input  1  transaction offered.
REQ-012 tx_ready  output  1  transaction accepted when tx_valid && tx_ready.
REQ-013 tx_from, tx_to  input  2 each  source and destination account index.
REQ-014 tx_amount  input  BAL_W  transfer amount.
REQ-015 tx_done  output  1  one-cycle pulse at transaction completion.
REQ-016 tx_ok  output  1  valid with tx_done: 1 = applied, 0 = rejected.

Function
REQ-017 FSM states: IDLE=000, REQUEST=001, WAIT_LOAD=010, COMPUTE=011, COMMIT=100.
- process SHALL equal the current state encoding.
REQ-018 IDLE:
- tx_ready = done.
- On a handshake, latch tx_from, tx_to and tx_amount, then go to REQUEST.
REQ-019 REQUEST:
- Hold load_memory=1.
- Go to WAIT_LOAD on the first cycle done=0.
REQ-020 WAIT_LOAD:
- Capture mem_q into the balance register every cycle load_registers=1.
- Go to COMPUTE on the cycle load_registers falls from 1 to 0.
REQ-021 COMPUTE (1 cycle): reject if any of the following hold:
- tx_from == tx_to;
- either index >= NUM_ACCTS;
- balance[from] < amount.
REQ-022 On accept: balance[from] -= amount and balance[to] += amount, registered into datapath_out. On reject: datapath_out = captured word unchanged.
REQ-023 COMMIT:
- Hold datapath_out stable.
- When done returns to 1, pulse tx_done with tx_ok and go to IDLE.
REQ-024 A rejected transaction SHALL still pass through COMMIT, so the memory controller is never left waiting for process=3'b100.
REQ-025 tx_valid outside IDLE SHALL be ignored (tx_ready=0); no queuing.
REQ-026 tx_amount=0 with valid, distinct indices SHALL be accepted, leaving the word unchanged.
REQ-027 Arithmetic SHALL be unsigned BAL_W bits; subtraction never underflows, because of the REQ-021 check.
REQ-028 Transaction latency from handshake to tx_done = 3 cycles + memory-controller read and write-back times.

Reset
REQ-029 While resetn=0 at a clock edge, the block SHALL enter IDLE and clear the following to 0:
- balance register, datapath_out, latched transaction;
- load_memory, tx_done, tx_ok.
REQ-030 A reset mid-transaction SHALL abort it with no tx_done pulse.
REQ-031 After reset, tx_ready SHALL follow done.

Configuration
REQ-032 Macro TX_PROC_OVERFLOW_CHECK_EN:
- Defined: COMPUTE also rejects when balance[to] + amount exceeds 2^BAL_W-1.
- Undefined: the destination sum wraps modulo 2^BAL_W and the transaction is accepted.

Structure
REQ-033 Package txp_pkg SHALL hold the state encodings, BAL_W default, NUM_ACCTS default and constant PROC_COMMIT=3'b100.
REQ-034 Sub-module balance_update SHALL implement the validity check and new-word computation combinationally; the FSM and registers stay in transaction_processor.

Verification
REQ-035 Basic transfer:
- Stimulus: mem_q=0x0003_0005_000A, transfer 0->1, amount 4.
- Required: datapath_out=0x0003_0009_0006 in COMMIT; tx_ok=1.
REQ-036 Insufficient funds:
- Stimulus: same word, transfer 2->0, amount 4.
- Required: datapath_out=0x0003_0005_000A; tx_ok=0; COMMIT still reached.
REQ-037 Self-transfer and index 3:
- Stimulus: from=to=1, then to=3.
- Required: both rejected, word unchanged, tx_done pulses once each.
REQ-038 Overflow:
- Stimulus: account 1 = 0xFFFF, transfer 0->1, amount 1, account 0 = 0x000A.
- Required with macro: rejected.
- Required without macro: accepted, account 1 = 0x0000, account 0 = 0x0009.
REQ-039 Busy and handshake:
- Stimulus: tx_valid held high through a transaction.
- Required: tx_ready=0 outside IDLE; a second handshake only after tx_done; load_memory drops once done=0.
REQ-040 Reset mid-transaction:
- Stimulus: resetn=0 during WAIT_LOAD.
- Required: IDLE next cycle, outputs 0, no tx_done.
